// File: rtl/bfp_pkg.sv
// Shared types and constants for the streaming BFP -> BF16 unpacker.
package bfp_pkg;

    // Packed BF16 word layout, MSB first.
    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] frac;
    } bf16_t;

    localparam int          BF16_EXP_MAX       = 255;
    localparam logic [15:0] BF16_MAX_FINITE    = 16'h7F7F;
    localparam logic [15:0] BF16_INF           = 16'h7F80;
    localparam int          BFP_STREAM_LATENCY = 4;

endpackage

// File: rtl/bfp_lane_normalizer.sv
// One lane of the unpacker: magnitude/sign split, leading-zero count,
// normalisation, then rounding and BF16 classification. Four register
// stages share a single enable so every lane stalls in lockstep.
module bfp_lane_normalizer
    import bfp_pkg::*;
#(
    parameter int    EXPONENT_SIZE = 8,
    parameter int    MANTISSA_SIZE = 8,
    parameter int    EXP_OFFSET    = 7,
    parameter bit    ROUND_RNE     = 1'b1,
    parameter bit    SATURATE      = 1'b1,
    parameter string FAMILY        = "S10"
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [EXPONENT_SIZE-1:0] in_shared_exp,
    input  logic [MANTISSA_SIZE-1:0] in_mant,
    output logic [15:0]              out_word,
    output logic                     out_sat,
    output logic                     out_ftz
);

    localparam int M   = MANTISSA_SIZE;
    localparam int EW  = EXPONENT_SIZE + 2;   // biased block exponent
    localparam int XW  = EW + 1;              // headroom for -lz and rounding carry
    localparam int LZW = $clog2(M + 1);
    localparam int FB  = M - 1;               // fraction bits below the implicit one

    localparam logic signed [EW-1:0] OFFSET_EW = EW'(EXP_OFFSET);
    localparam logic signed [XW-1:0] ONE_X     = XW'(1);
    localparam logic signed [XW-1:0] ZERO_X    = '0;
    localparam logic signed [XW-1:0] EXP_MAX_X = XW'(BF16_EXP_MAX);
    localparam logic [15:0]          OVF_WORD  = SATURATE ? BF16_MAX_FINITE : BF16_INF;

    // Stage 1
    logic                 sign_s1_q, sign_s1_d;
    logic [M-1:0]         mag_s1_q, mag_s1_d;
    logic signed [EW-1:0] e_base_s1_q, e_base_s1_d;
    // Stage 2
    logic                 sign_s2_q;
    logic [M-1:0]         mag_s2_q;
    logic signed [EW-1:0] e_base_s2_q;
    logic [LZW-1:0]       lz_s2_q, lz_s2_d;
    // Stage 3
    logic                 sign_s3_q;
    logic                 zero_s3_q, zero_s3_d;
    logic [FB-1:0]        frac_s3_q, frac_s3_d;
    logic signed [XW-1:0] e_s3_q, e_s3_d;
    // Stage 4
    bf16_t                word_q, word_d;
    logic                 sat_q, sat_d;
    logic                 ftz_q, ftz_d;

    // Rounding helpers
    logic [6:0]           frac_raw;
    logic                 guard;
    logic                 sticky;
    logic                 round_up;
    logic                 carry;
    logic [6:0]           frac_rnd;
    logic signed [XW-1:0] e_rnd;

    // S1: split sign and magnitude; the most negative code maps to 2^(M-1) exactly.
    always_comb begin
        sign_s1_d   = in_mant[M-1];
        mag_s1_d    = in_mant[M-1] ? (~in_mant + M'(1)) : in_mant;
        e_base_s1_d = $signed({2'b00, in_shared_exp}) + OFFSET_EW;
    end

    // S2: leading-zero count over M bits (M for a zero magnitude).
    generate
        if (FAMILY == "A10") begin : g_lzc_a10
            logic seen;
            // MSB-first scan that stops at the first set bit.
            always_comb begin
                seen    = 1'b0;
                lz_s2_d = LZW'(M);
                for (int i = M - 1; i >= 0; i--) begin
                    if (!seen && mag_s1_q[i]) begin
                        lz_s2_d = LZW'(M - 1 - i);
                        seen    = 1'b1;
                    end
                end
            end
        end else begin : g_lzc_s10
            // LSB-first priority chain; the highest set bit wins last.
            always_comb begin
                lz_s2_d = LZW'(M);
                for (int i = 0; i < M; i++) begin
                    if (mag_s1_q[i]) lz_s2_d = LZW'(M - 1 - i);
                end
            end
        end
    endgenerate

    // S3: normalise so the implicit one sits at the MSB (dropped), adjust exponent.
    always_comb begin
        frac_s3_d = (M - 1)'(mag_s2_q << lz_s2_q);
        zero_s3_d = (mag_s2_q == '0);
        e_s3_d    = $signed({e_base_s2_q[EW-1], e_base_s2_q})
                  - $signed({{(XW - LZW){1'b0}}, lz_s2_q}) + ONE_X;
    end

    // S4 fraction extraction: top seven bits, plus guard/sticky when rounding wide mantissas.
    generate
        if (FB >= 7) begin : g_frac_wide
            assign frac_raw = frac_s3_q[FB-1 -: 7];
            if (ROUND_RNE && (FB > 7)) begin : g_rne
                assign guard = frac_s3_q[FB-8];
                if (FB > 8) begin : g_sticky
                    assign sticky = |frac_s3_q[FB-9:0];
                end else begin : g_no_sticky
                    assign sticky = 1'b0;
                end
            end else begin : g_trunc
                assign guard  = 1'b0;
                assign sticky = 1'b0;
                if (FB > 7) begin : g_drop
                    logic unused_low_bits;
                    assign unused_low_bits = ^frac_s3_q[FB-8:0];
                end
            end
        end else begin : g_frac_narrow
            assign frac_raw = {frac_s3_q, {(7 - FB){1'b0}}};
            assign guard    = 1'b0;
            assign sticky   = 1'b0;
        end
    endgenerate

    // S4: round-to-nearest-even, then classify zero / flush / overflow / normal.
    always_comb begin
        round_up          = guard & (sticky | frac_raw[0]);
        {carry, frac_rnd} = {1'b0, frac_raw} + {7'd0, round_up};
        e_rnd             = e_s3_q + $signed({{(XW - 1){1'b0}}, carry});
        word_d            = '0;
        sat_d             = 1'b0;
        ftz_d             = 1'b0;
        if (zero_s3_q) begin
            word_d = '0;
        end else if (e_rnd <= ZERO_X) begin
            word_d.sign = sign_s3_q;
            ftz_d       = 1'b1;
        end else if (e_rnd >= EXP_MAX_X) begin
            word_d = bf16_t'({sign_s3_q, OVF_WORD[14:0]});
            sat_d  = 1'b1;
        end else begin
            word_d.sign = sign_s3_q;
            word_d.exp  = e_rnd[7:0];
            word_d.frac = frac_rnd;
        end
    end

    // All lane stages advance together on en; reset clears every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_s1_q   <= 1'b0;
            mag_s1_q    <= '0;
            e_base_s1_q <= '0;
            sign_s2_q   <= 1'b0;
            mag_s2_q    <= '0;
            e_base_s2_q <= '0;
            lz_s2_q     <= '0;
            sign_s3_q   <= 1'b0;
            zero_s3_q   <= 1'b0;
            frac_s3_q   <= '0;
            e_s3_q      <= '0;
            word_q      <= '0;
            sat_q       <= 1'b0;
            ftz_q       <= 1'b0;
        end else if (en) begin
            sign_s1_q   <= sign_s1_d;
            mag_s1_q    <= mag_s1_d;
            e_base_s1_q <= e_base_s1_d;
            sign_s2_q   <= sign_s1_q;
            mag_s2_q    <= mag_s1_q;
            e_base_s2_q <= e_base_s1_q;
            lz_s2_q     <= lz_s2_d;
            sign_s3_q   <= sign_s2_q;
            zero_s3_q   <= zero_s3_d;
            frac_s3_q   <= frac_s3_d;
            e_s3_q      <= e_s3_d;
            word_q      <= word_d;
            sat_q       <= sat_d;
            ftz_q       <= ftz_d;
        end
    end

    assign out_word = word_q;
    assign out_sat  = sat_q;
    assign out_ftz  = ftz_q;

endmodule

// File: rtl/bfp_to_bf16_stream.sv
// Streaming BFP block -> NUM packed BF16 words with valid/ready flow control.
// Holds the valid/last control pipeline, per-beat flag reduction and the
// saturation beat counter; the datapath lives in the per-lane normalisers.
module bfp_to_bf16_stream
    import bfp_pkg::*;
#(
    parameter int    NUM           = 16,
    parameter int    EXPONENT_SIZE = 8,
    parameter int    MANTISSA_SIZE = 8,
    parameter int    EXP_OFFSET    = 7,
    parameter bit    ROUND_RNE     = 1'b1,
    parameter bit    SATURATE      = 1'b1,
    parameter string FAMILY        = "S10"
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [EXPONENT_SIZE-1:0]         in_shared_exp,
    input  logic [NUM*MANTISSA_SIZE-1:0]     in_sdata,
    input  logic                             in_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM*16-1:0]                out_bf16,
    output logic                             out_last,
    output logic                             out_sat,
    output logic                             out_ftz,
    output logic [31:0]                      sat_count
);

    localparam int LAT = BFP_STREAM_LATENCY;

    logic           en;
    logic [LAT-1:0] valid_q, valid_d;
    logic [LAT-1:0] last_q, last_d;
    logic [NUM-1:0] lane_sat;
    logic [NUM-1:0] lane_ftz;
    logic [31:0]    sat_count_q, sat_count_d;

    // The whole pipeline moves whenever the output slot is empty or being taken.
    assign en        = ~out_valid | out_ready;
    assign in_ready  = en;
    assign out_valid = valid_q[LAT-1];
    assign out_last  = last_q[LAT-1];

    generate
        for (genvar gi = 0; gi < NUM; gi++) begin : g_lane
            bfp_lane_normalizer #(
                .EXPONENT_SIZE (EXPONENT_SIZE),
                .MANTISSA_SIZE (MANTISSA_SIZE),
                .EXP_OFFSET    (EXP_OFFSET),
                .ROUND_RNE     (ROUND_RNE),
                .SATURATE      (SATURATE),
                .FAMILY        (FAMILY)
            ) u_lane (
                .clk           (clk),
                .rst           (rst),
                .en            (en),
                .in_shared_exp (in_shared_exp),
                .in_mant       (in_sdata[gi*MANTISSA_SIZE +: MANTISSA_SIZE]),
                .out_word      (out_bf16[gi*16 +: 16]),
                .out_sat       (lane_sat[gi]),
                .out_ftz       (lane_ftz[gi])
            );
        end
    endgenerate

    // Lane flags from bubbles are meaningless, so qualify the reduction with out_valid.
    assign out_sat = out_valid & (|lane_sat);
    assign out_ftz = out_valid & (|lane_ftz);

    // Shift valid and last (last only on real beats) alongside the lane data.
    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        if (en) begin
            valid_d = {valid_q[LAT-2:0], in_valid};
            last_d  = {last_q[LAT-2:0], in_valid & in_last};
        end
    end

    // Count accepted saturated beats, sticking at all-ones.
    always_comb begin
        sat_count_d = sat_count_q;
        if (out_valid && out_ready && out_sat && (sat_count_q != 32'hFFFF_FFFF)) begin
            sat_count_d = sat_count_q + 32'd1;
        end
    end

    // Control and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            last_q      <= '0;
            sat_count_q <= '0;
        end else begin
            valid_q     <= valid_d;
            last_q      <= last_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_bfp_to_bf16_stream.sv
// Directed and randomised-handshake checks of the BFP -> BF16 stream.
// Three builds run in lockstep: 8-bit saturating, 8-bit infinity, 12-bit RNE.
module tb_bfp_to_bf16_stream;

    localparam int NUM      = 4;
    localparam int N_DIR    = 5;
    localparam int N_RAND   = 2000;
    localparam int CYC_MAX  = 40000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  exp_ab = '0;
    logic [31:0] sdata_ab = '0;
    logic [7:0]  exp_c = '0;
    logic [47:0] sdata_c = '0;

    logic        a_in_ready, a_out_valid, a_out_last, a_out_sat, a_out_ftz;
    logic [63:0] a_out_bf16;
    logic [31:0] a_sat_count;
    logic        b_in_ready, b_out_valid, b_out_last, b_out_sat, b_out_ftz;
    logic [63:0] b_out_bf16;
    logic [31:0] b_sat_count;
    logic        c_in_ready, c_out_valid, c_out_last, c_out_sat, c_out_ftz;
    logic [63:0] c_out_bf16;
    logic [31:0] c_sat_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bfp_to_bf16_stream #(.NUM(NUM)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_shared_exp(exp_ab), .in_sdata(sdata_ab), .in_last(in_last),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_bf16(a_out_bf16),
        .out_last(a_out_last), .out_sat(a_out_sat), .out_ftz(a_out_ftz),
        .sat_count(a_sat_count)
    );

    bfp_to_bf16_stream #(.NUM(NUM), .SATURATE(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_shared_exp(exp_ab), .in_sdata(sdata_ab), .in_last(in_last),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_bf16(b_out_bf16),
        .out_last(b_out_last), .out_sat(b_out_sat), .out_ftz(b_out_ftz),
        .sat_count(b_sat_count)
    );

    bfp_to_bf16_stream #(.NUM(NUM), .MANTISSA_SIZE(12), .ROUND_RNE(1'b1), .FAMILY("A10")) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_shared_exp(exp_c), .in_sdata(sdata_c), .in_last(in_last),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_bf16(c_out_bf16),
        .out_last(c_out_last), .out_sat(c_out_sat), .out_ftz(c_out_ftz),
        .sat_count(c_sat_count)
    );

    task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    // Hand-computed directed vectors; lane 0 is the least significant slice.
    logic [7:0]  d_exp_ab [N_DIR] = '{8'd120, 8'd120, 8'd250, 8'd247, 8'd248};
    logic [31:0] d_sd_ab  [N_DIR] = '{32'h40404040, 32'hC0000180, 32'h0001407F,
                                      32'hFF817F40, 32'h0000C040};
    logic [63:0] d_wa     [N_DIR] = '{64'h3F80_3F80_3F80_3F80, 64'hBF80_0000_3C80_C000,
                                      64'h0000_7D80_7F7F_7F7F, 64'hFC00_FF7E_7F7E_7F00,
                                      64'h0000_0000_FF7F_7F7F};
    logic [63:0] d_wb     [N_DIR] = '{64'h3F80_3F80_3F80_3F80, 64'hBF80_0000_3C80_C000,
                                      64'h0000_7D80_7F80_7F80, 64'hFC00_FF7E_7F7E_7F00,
                                      64'h0000_0000_FF80_7F80};
    logic [7:0]  d_exp_c  [N_DIR] = '{8'd120, 8'd120, 8'd0, 8'd120, 8'd0};
    logic [47:0] d_sd_c   [N_DIR] = '{48'h403_406_40C_404, 48'h000_800_801_7FF,
                                      48'hFFF_010_008_001, 48'h200_C00_400_000,
                                      48'h000_000_000_000};
    logic [63:0] d_wc     [N_DIR] = '{64'h3F80_3F81_3F82_3F80, 64'h0000_C000_C000_4000,
                                      64'h8000_0080_0000_0000, 64'h3F00_BF80_3F80_0000,
                                      64'h0000_0000_0000_0000};
    logic        d_sat    [N_DIR] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        d_ftz_c  [N_DIR] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        d_last   [N_DIR] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reference for one 8-bit lane with bias 7: value = mag * 2^(exp+7-133).
    function automatic logic [15:0] lane_model(input int exp_in, input logic [7:0] m,
                                               input bit sat_mode, output bit sat, output bit ftz);
        int mag;
        int p;
        int e;
        int frac;
        logic [15:0] res;
        sat = 1'b0;
        ftz = 1'b0;
        mag = m[7] ? (256 - int'(m)) : int'(m);
        if (mag == 0) return 16'h0000;
        p = 7;
        while (((mag >> p) & 1) == 0) p--;
        e    = exp_in + 7 + p - 6;
        frac = (mag << (7 - p)) & 127;
        if (e <= 0) begin
            ftz = 1'b1;
            res = {m[7], 15'h0000};
        end else if (e >= 255) begin
            sat = 1'b1;
            res = sat_mode ? {m[7], 15'h7F7F} : {m[7], 15'h7F80};
        end else begin
            res = {m[7], 8'(e), 7'(frac)};
        end
        return res;
    endfunction

    typedef struct packed {
        logic [63:0] wa;
        logic [63:0] wb;
        logic        sat;
        logic        ftz;
        logic        last;
    } beat_t;

    beat_t sb_q[$];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int    oi;
        int    first_k;
        int    sent;
        int    got;
        int    cyc;
        int    exp_sat;
        bit    accepted;
        bit    hold_v;
        logic [66:0] hold_snap;
        beat_t pend;
        beat_t e;
        bit    s;
        bit    f;
        logic [7:0] r_lane;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("rst_valid", 128'(a_out_valid), 128'(0));
        check_value("rst_bf16", 128'(a_out_bf16), 128'(0));
        check_value("rst_flags", 128'({a_out_last, a_out_sat, a_out_ftz}), 128'(0));
        check_value("rst_satcnt", 128'(a_sat_count), 128'(0));
        check_value("rst_bf16_c", 128'(c_out_bf16), 128'(0));
        check_value("rst_in_ready", 128'(a_in_ready), 128'(1));
        rst = 1'b0;

        // Directed beats at full throughput
        oi      = 0;
        first_k = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (k < N_DIR) begin
                in_valid = 1'b1;
                exp_ab   = d_exp_ab[k];
                sdata_ab = d_sd_ab[k];
                exp_c    = d_exp_c[k];
                sdata_c  = d_sd_c[k];
                in_last  = d_last[k];
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            #1;
            if (a_out_valid) begin
                if (first_k < 0) first_k = k;
                if (oi < N_DIR) begin
                    check_value("dir_a", 128'(a_out_bf16), 128'(d_wa[oi]));
                    check_value("dir_b", 128'(b_out_bf16), 128'(d_wb[oi]));
                    check_value("dir_c", 128'(c_out_bf16), 128'(d_wc[oi]));
                    check_value("dir_a_flags", 128'({a_out_sat, a_out_ftz, a_out_last}),
                                128'({d_sat[oi], 1'b0, d_last[oi]}));
                    check_value("dir_b_flags", 128'({b_out_sat, b_out_ftz}), 128'({d_sat[oi], 1'b0}));
                    check_value("dir_c_flags", 128'({c_out_valid, c_out_sat, c_out_ftz, c_out_last}),
                                128'({1'b1, 1'b0, d_ftz_c[oi], d_last[oi]}));
                end
                oi++;
            end
        end
        check_value("latency", 128'(first_k), 128'(4));
        check_value("dir_beats", 128'(oi), 128'(N_DIR));
        check_value("dir_satcnt_a", 128'(a_sat_count), 128'(2));
        check_value("dir_satcnt_b", 128'(b_sat_count), 128'(2));
        check_value("dir_satcnt_c", 128'(c_sat_count), 128'(0));

        // Random valid/ready against the reference model
        exp_c    = '0;
        sdata_c  = '0;
        sent     = 0;
        got      = 0;
        cyc      = 0;
        exp_sat  = 2;
        accepted = 1'b0;
        hold_v   = 1'b0;
        hold_snap = '0;
        pend     = '0;
        while ((got < N_RAND) && (cyc < CYC_MAX)) begin
            @(negedge clk);
            cyc++;
            if (accepted) begin
                in_valid = 1'b0;
                accepted = 1'b0;
            end
            if (!in_valid && (sent < N_RAND) && ($urandom_range(0, 9) < 7)) begin
                exp_ab   = 8'($urandom_range(0, 255));
                in_last  = ($urandom_range(0, 7) == 0);
                pend     = '0;
                for (int l = 0; l < NUM; l++) begin
                    r_lane = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                    sdata_ab[l*8 +: 8] = r_lane;
                    pend.wa[l*16 +: 16] = lane_model(int'(exp_ab), r_lane, 1'b1, s, f);
                    pend.sat = pend.sat | s;
                    pend.ftz = pend.ftz | f;
                    pend.wb[l*16 +: 16] = lane_model(int'(exp_ab), r_lane, 1'b0, s, f);
                end
                pend.last = in_last;
                in_valid  = 1'b1;
            end
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (hold_v && !a_out_valid) check_value("stall_valid", 128'(a_out_valid), 128'(1));
            if (a_out_valid) begin
                if (hold_v) begin
                    check_value("stall_hold", 128'({a_out_bf16, a_out_last, a_out_sat, a_out_ftz}),
                                128'(hold_snap));
                end
                if (out_ready) begin
                    if (sb_q.size() == 0) begin
                        check_value("rand_dup", 128'(sb_q.size()), 128'(1));
                    end else begin
                        e = sb_q.pop_front();
                        check_value("rand_a", 128'({a_out_bf16, a_out_sat, a_out_ftz, a_out_last}),
                                    128'({e.wa, e.sat, e.ftz, e.last}));
                        check_value("rand_b", 128'(b_out_bf16), 128'(e.wb));
                        if (e.sat) exp_sat++;
                    end
                    got++;
                    hold_v = 1'b0;
                end else begin
                    hold_v    = 1'b1;
                    hold_snap = {a_out_bf16, a_out_last, a_out_sat, a_out_ftz};
                end
            end else begin
                hold_v = 1'b0;
            end
            if (in_valid && a_in_ready) begin
                sb_q.push_back(pend);
                sent++;
                accepted = 1'b1;
            end
        end
        check_value("rand_done", 128'(got), 128'(N_RAND));
        check_value("rand_left", 128'(sb_q.size()), 128'(0));
        check_value("rand_satcnt_a", 128'(a_sat_count), 128'(exp_sat));
        check_value("rand_satcnt_b", 128'(b_sat_count), 128'(exp_sat));

        // Reset while the pipeline is full and stalled
        @(negedge clk);
        in_valid  = 1'b1;
        exp_ab    = 8'd250;
        sdata_ab  = 32'h7F7F7F7F;
        out_ready = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check_value("pre_rst_valid", 128'(a_out_valid), 128'(1));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_value("mid_rst_valid", 128'({a_out_valid, b_out_valid, c_out_valid}), 128'(0));
        check_value("mid_rst_satcnt", 128'(a_sat_count), 128'(0));
        check_value("mid_rst_bf16", 128'(a_out_bf16), 128'(0));
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            check_value("post_rst_quiet", 128'({a_out_valid, a_sat_count}), 128'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
